ysyx_22050612_wb_arbiter: RTL

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port between NREQ write-back requesters (EXU, LSU, MDU) using round-robin valid/ready arbitration, and drives the registered write strobe, address and data into the register file. It also keeps a per-register busy scoreboard so that issue logic can stall on outstanding writes. It sits between the execute/memory units and the register file.

---
 rtl/ysyx_22050612_wb_arbiter_pkg.sv | 18 +
 rtl/ysyx_22050612_wb_arbiter_if.sv | 36 +++
 rtl/ysyx_22050612_rr_arbiter.sv | 53 +++++
 rtl/ysyx_22050612_wb_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/ysyx_22050612_wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: requester indices, default widths
// and a pointer-width helper for round-robin arbiters.
package ysyx_22050612_wb_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NREQ       = 3;

    localparam int REQ_EXU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    // A one-requester arbiter still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050612_wb_arbiter_if.sv
// Bus bundle between the write-back requesters / issue stage (master) and the
// write-back arbiter (slave).
interface ysyx_22050612_wb_arbiter_if
    import ysyx_22050612_wb_arbiter_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       issue_valid;
    logic [ADDR_WIDTH-1:0]      issue_rd;
    logic                       issue_ready;
    logic                       flush;
    logic [ADDR_WIDTH-1:0]      rs1;
    logic [ADDR_WIDTH-1:0]      rs2;
    logic                       rs1_busy;
    logic                       rs2_busy;
    logic                       rf_wen;
    logic [ADDR_WIDTH-1:0]      rf_waddr;
    logic [DATA_WIDTH-1:0]      rf_wdata;

    modport master (
        output req_valid, req_addr, req_data, issue_valid, issue_rd, flush, rs1, rs2,
        input  req_ready, issue_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data, issue_valid, issue_rd, flush, rs1, rs2,
        output req_ready, issue_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/ysyx_22050612_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the last
// granted one; the pointer moves only when the caller reports a handshake.
module ysyx_22050612_rr_arbiter
    import ysyx_22050612_wb_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);
    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0] last_grant_reg;
    logic [PW-1:0] last_grant_next;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;
    logic          found;

    // Offsets 1..NREQ visit every requester once, the last winner last.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant_reg;
        cand      = '0;
        found     = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = PW'((int'(last_grant_reg) + off) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_next = last_grant_reg;
        if (advance && found) begin
            last_grant_next = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= PW'(NREQ - 1);
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the integer register file: shares the
// single write port among the requesters and tracks registers with pending writes.
module ysyx_22050612_wb_arbiter
    import ysyx_22050612_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREQ       = DEF_NREQ
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_22050612_wb_arbiter_if.slave    bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [NREQ-1:0]       grant;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
    logic [DATA_WIDTH-1:0] data_arr [NREQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_wen_reg, rf_wen_next;
    logic [ADDR_WIDTH-1:0] rf_waddr_reg, rf_waddr_next;
    logic [DATA_WIDTH-1:0] rf_wdata_reg, rf_wdata_next;

    logic [NREGS-1:0]      busy_reg, busy_next;
    logic                  clearing;
    logic                  issue_ok;
    logic                  issue_set;

    ysyx_22050612_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (handshake),
        .grant   (grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign handshake     = |(bus.req_valid & grant);
    assign bus.req_ready = grant;

    // Grant is one-hot, so an OR of masked slices is the selected request.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | addr_arr[i];
                sel_data = sel_data | data_arr[i];
            end
        end
    end

    always_comb begin
        rf_wen_next   = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        if (handshake) begin
            rf_wen_next   = (sel_addr != '0);
            rf_waddr_next = sel_addr;
            rf_wdata_next = sel_data;
        end
    end

    assign clearing  = rf_wen_reg && busy_reg[rf_waddr_reg];
    assign issue_ok  = !bus.flush &&
                       ((bus.issue_rd == '0) || !busy_reg[bus.issue_rd] ||
                        (clearing && (rf_waddr_reg == bus.issue_rd)));
    assign issue_set = bus.issue_valid && issue_ok && (bus.issue_rd != '0);

    // Clear is applied before set so a same-cycle reallocation keeps the bit.
    always_comb begin
        busy_next = busy_reg;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (clearing) begin
                busy_next[rf_waddr_reg] = 1'b0;
            end
            if (issue_set) begin
                busy_next[bus.issue_rd] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_reg   <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            busy_reg     <= '0;
        end else begin
            rf_wen_reg   <= rf_wen_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
            busy_reg     <= busy_next;
        end
    end

    assign bus.issue_ready = issue_ok;
    assign bus.rs1_busy    = busy_reg[bus.rs1];
    assign bus.rs2_busy    = busy_reg[bus.rs2];
    assign bus.rf_wen      = rf_wen_reg;
    assign bus.rf_waddr    = rf_waddr_reg;
    assign bus.rf_wdata    = rf_wdata_reg;

endmodule
